// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: op encodings, FSM states
// and the iteration counter sizing.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_NEG_IN  = 2'b01,
        ST_ITER    = 2'b10,
        ST_NEG_OUT = 2'b11
    } state_e;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned CNT_W     = $clog2(DEF_WIDTH) + 1;

    // Counter width for an arbitrary operand width.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/muldiv_twos_negate.sv
// Two's-complement negation: bitwise complement followed by an increment.
module twos_negate #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_x,
    output logic [WIDTH-1:0] o_y
);

    logic [WIDTH-1:0] w_cpl;

    assign w_cpl = ~i_x;
    assign o_y   = w_cpl + WIDTH'(1);

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU controller: radix-2 shift-add multiply and
// restoring divide sharing one adder, with sign fix-up before and after.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             dbz
);

    localparam int unsigned CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_e             r_state;
    op_e                r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_cnt;
    logic               r_sign_q;
    logic               r_sign_r;
    logic               r_busy;
    logic               r_done;
    logic               r_dbz;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_signed;
    logic               w_is_div;
    logic [WIDTH-1:0]   w_neg_a;
    logic [WIDTH-1:0]   w_neg_b;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [2*WIDTH-1:0] w_neg_wide;
    logic [WIDTH-1:0]   w_neg_rem;
    logic [WIDTH-1:0]   w_rem_sh;
    logic [WIDTH-1:0]   w_add_x;
    logic [WIDTH-1:0]   w_add_y;
    logic               w_add_ci;
    logic [WIDTH:0]     w_sum;
    logic               w_div_ok;
    logic [2*WIDTH-1:0] w_iter_acc;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    assign w_signed = (r_op == OP_MULT) || (r_op == OP_DIV);
    assign w_is_div = (r_op == OP_DIVU) || (r_op == OP_DIV);

    twos_negate #(.WIDTH(WIDTH))     u_neg_a    (.i_x(r_a),                     .o_y(w_neg_a));
    twos_negate #(.WIDTH(WIDTH))     u_neg_b    (.i_x(r_b),                     .o_y(w_neg_b));
    twos_negate #(.WIDTH(2*WIDTH))   u_neg_wide (.i_x(r_acc),                   .o_y(w_neg_wide));
    twos_negate #(.WIDTH(WIDTH))     u_neg_rem  (.i_x(r_acc[2*WIDTH-1:WIDTH]),  .o_y(w_neg_rem));

    assign w_a_mag = (w_signed && r_a[WIDTH-1]) ? w_neg_a : r_a;
    assign w_b_mag = (w_signed && r_b[WIDTH-1]) ? w_neg_b : r_b;

    // Shared adder: accumulate for multiply, trial-subtract for divide.
    assign w_rem_sh = {r_acc[2*WIDTH-2:WIDTH], r_acc[WIDTH-1]};

    always_comb begin
        w_add_x  = r_acc[2*WIDTH-1:WIDTH];
        w_add_y  = r_acc[0] ? r_a : '0;
        w_add_ci = 1'b0;
        if (w_is_div) begin
            w_add_x  = w_rem_sh;
            w_add_y  = ~r_b;
            w_add_ci = 1'b1;
        end
    end

    assign w_sum = {1'b0, w_add_x} + {1'b0, w_add_y} + (WIDTH+1)'(w_add_ci);

    // The bit shifted out of the remainder means it already exceeds any divisor.
    assign w_div_ok = r_acc[2*WIDTH-1] | w_sum[WIDTH];

    always_comb begin
        w_iter_acc = {w_sum, r_acc[WIDTH-1:1]};
        if (w_is_div) begin
            w_iter_acc = {(w_div_ok ? w_sum[WIDTH-1:0] : w_rem_sh),
                          r_acc[WIDTH-2:0], w_div_ok};
        end
    end

    // Quotient negation is the low half of the wide negate.
    always_comb begin
        w_res_hi = r_sign_q ? w_neg_wide[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
        w_res_lo = r_sign_q ? w_neg_wide[WIDTH-1:0]       : r_acc[WIDTH-1:0];
        if (w_is_div) begin
            w_res_hi = r_sign_r ? w_neg_rem : r_acc[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_op     <= OP_MULTU;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op    <= op_e'(op);
                        r_a     <= a;
                        r_b     <= b;
                        r_busy  <= 1'b1;
                        r_state <= ST_NEG_IN;
                    end
                end
                ST_NEG_IN: begin
                    r_a      <= w_a_mag;
                    r_b      <= w_b_mag;
                    r_acc    <= {{WIDTH{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
                    r_sign_q <= w_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
                    r_sign_r <= w_signed & r_a[WIDTH-1];
                    r_cnt    <= '0;
                    r_state  <= ST_ITER;
                    if (w_is_div && (r_b == '0)) begin
                        r_hi    <= r_a;
                        r_lo    <= '1;
                        r_dbz   <= 1'b1;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_ITER: begin
                    r_acc <= w_iter_acc;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST_CNT) begin
                        r_state <= ST_NEG_OUT;
                    end
                end
                ST_NEG_OUT: begin
                    r_hi    <= w_res_hi;
                    r_lo    <= w_res_lo;
                    r_dbz   <= 1'b0;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign dbz  = r_dbz;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed cases plus randomized
// back-to-back operations against an arithmetic reference model.
module tb_muldiv_sequencer;

    localparam int unsigned W = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;

    int n_checks;
    int n_errors;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo),
        .dbz   (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: {dbz, hi, lo} from plain integer arithmetic.
    function automatic logic [2*W:0] ref_model(input logic [1:0] o, input logic [W-1:0] x,
                                               input logic [W-1:0] y);
        longint      sx;
        longint      sy;
        logic [63:0] p;
        logic [W-1:0] q;
        logic [W-1:0] r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'b00: begin
                p = {32'd0, x} * {32'd0, y};
                return {1'b0, p};
            end
            2'b01: begin
                p = 64'(sx * sy);
                return {1'b0, p};
            end
            2'b10: begin
                if (y == 0) return {1'b1, x, 32'hFFFFFFFF};
                q = x / y;
                r = x % y;
                return {1'b0, r, q};
            end
            default: begin
                if (y == 0) return {1'b1, x, 32'hFFFFFFFF};
                q = W'(sx / sy);
                r = W'(sx % sy);
                return {1'b0, r, q};
            end
        endcase
    endfunction

    // Present a request; returns just after the accepting edge.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_accept", 64'(busy), 64'd1);
        check("done_low_after_accept", 64'(done), 64'd0);
    endtask

    // Count edges until done, bounded.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
            if (done) break;
        end
        if (!done) check("done_timeout", 64'(done), 64'd1);
    endtask

    task automatic expect_result(input string tag, input logic [1:0] o,
                                 input logic [W-1:0] x, input logic [W-1:0] y,
                                 input int cycles);
        logic [2*W:0] e;
        int           exp_lat;
        e       = ref_model(o, x, y);
        exp_lat = e[2*W] ? 1 : W + 2;
        check({tag, "_lat"}, 64'(cycles), 64'(exp_lat));
        check({tag, "_hi"},  64'(hi),  64'(e[2*W-1:W]));
        check({tag, "_lo"},  64'(lo),  64'(e[W-1:0]));
        check({tag, "_dbz"}, 64'(dbz), 64'(e[2*W]));
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [W-1:0] x, input logic [W-1:0] y);
        int cyc;
        issue(o, x, y);
        wait_done(cyc);
        expect_result(tag, o, x, y, cyc);
    endtask

    initial begin
        int           cyc;
        logic [1:0]   ro;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        n_checks = 0;
        n_errors = 0;
        start    = 1'b0;
        op       = 2'b00;
        a        = '0;
        b        = '0;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi",   64'(hi),   64'd0);
        check("rst_lo",   64'(lo),   64'd0);
        check("rst_dbz",  64'(dbz),  64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases, including boundaries.
        run_op("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check("multu_max_hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFE);
        check("multu_max_lo_const", 64'(lo), 64'h0000_0000_0000_0001);
        @(posedge clk);
        #1;
        check("done_one_cycle", 64'(done), 64'd0);
        check("hold_hi", 64'(hi), 64'h0000_0000_FFFF_FFFE);
        run_op("mult_neg", 2'b01, 32'hFFFFFFFD, 32'd5);
        check("mult_neg_lo_const", 64'(lo), 64'h0000_0000_FFFF_FFF1);
        run_op("divu_100_7", 2'b10, 32'd100, 32'd7);
        run_op("div_neg7_2", 2'b11, 32'hFFFFFFF9, 32'd2);
        check("div_neg7_2_lo_const", 64'(lo), 64'h0000_0000_FFFF_FFFD);
        run_op("div_by_zero", 2'b11, 32'h12345678, 32'd0);
        check("dbz_hi_const", 64'(hi), 64'h0000_0000_1234_5678);
        run_op("div_wrap", 2'b11, 32'h80000000, 32'hFFFFFFFF);
        check("div_wrap_lo_const", 64'(lo), 64'h0000_0000_8000_0000);
        run_op("mult_minint_sq", 2'b01, 32'h80000000, 32'h80000000);
        check("mult_minint_hi_const", 64'(hi), 64'h0000_0000_4000_0000);

        // Start during busy is ignored; start in the done cycle is accepted.
        issue(2'b10, 32'd100, 32'd7);
        repeat (4) @(posedge clk);
        #1;
        op    = 2'b00;
        a     = 32'd3;
        b     = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(cyc);
        expect_result("ignored_start", 2'b10, 32'd100, 32'd7, cyc + 5);
        run_op("b2b_multu", 2'b00, 32'd3, 32'd3);

        // Asynchronous reset mid-operation.
        issue(2'b01, 32'hFFFF1234, 32'h00007777);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_hi",   64'(hi),   64'd0);
        check("midrst_lo",   64'(lo),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op("post_rst_multu", 2'b00, 32'd6, 32'd7);
        check("post_rst_lo_const", 64'(lo), 64'd42);

        // Randomized back-to-back operations.
        for (int i = 0; i < 60; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1:       rb = 32'hFFFFFFFF;
                2:       rb = W'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            run_op("rand", ro, ra, rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
